// File: rtl/sparhixcel_pkg.sv
// Shared array constants and types for the sparhixcel weight path.
// Holds the weight-vector type and the prefetch scheduler state encoding.
package sparhixcel_pkg;

  localparam int N_ROWS_ARRAY        = 9;
  localparam int F_WIDTH             = 8;
  localparam int WROM_ADDR_WIDTH     = 10;
  localparam int COUNTER_ROUND_WIDTH = 3;

  typedef logic [N_ROWS_ARRAY*F_WIDTH-1:0] weight_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } wps_state_t;

endpackage

// File: rtl/weight_prefetch_buffer.sv
// Shadow/active weight register pair: ROM data lands in the shadow, and the
// shadow is promoted to the active register whenever the array can take it.
module weight_prefetch_buffer
  import sparhixcel_pkg::*;
#(
  parameter int VEC_W = $bits(weight_vec_t)
) (
  input  logic             clk_i,
  input  logic             rd_weight_rst,
  input  logic             capture,
  input  logic [VEC_W-1:0] capture_data,
  input  logic             consume,
  output logic             promote,
  output logic [VEC_W-1:0] weight,
  output logic             weight_valid,
  output logic             shadow_full
);

  logic [VEC_W-1:0] shadow;
  logic             consume_live;

  // A consume frees the active slot in the same cycle, so a waiting shadow
  // moves up without a bubble.
  assign promote      = shadow_full & (~weight_valid | consume);
  assign consume_live = consume & weight_valid;

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      shadow       <= '0;
      shadow_full  <= 1'b0;
      weight       <= '0;
      weight_valid <= 1'b0;
    end else begin
      if (capture) begin
        shadow <= capture_data;
      end
      shadow_full <= capture | (shadow_full & ~promote);

      if (promote) begin
        weight       <= shadow;
        weight_valid <= 1'b1;
      end else if (consume_live) begin
        weight_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/weight_prefetch_scheduler.sv
// Sequences one weight-ROM read per round and double-buffers the result so
// the next round's fetch overlaps the array's use of the current one.
module weight_prefetch_scheduler
  import sparhixcel_pkg::*;
#(
  parameter int N_ROWS_ARRAY        = sparhixcel_pkg::N_ROWS_ARRAY,
  parameter int F_WIDTH             = sparhixcel_pkg::F_WIDTH,
  parameter int ADDR_WIDTH          = sparhixcel_pkg::WROM_ADDR_WIDTH,
  parameter int COUNTER_ROUND_WIDTH = sparhixcel_pkg::COUNTER_ROUND_WIDTH,
  parameter int ROM_LATENCY         = 1
) (
  input  logic                             clk_i,
  input  logic                             rd_weight_rst,
  input  logic                             start_i,
  input  logic [ADDR_WIDTH-1:0]            base_addr_i,
  input  logic [COUNTER_ROUND_WIDTH-1:0]   n_round_i,
  input  logic                             consume_i,
  output logic                             rom_rd_o,
  output logic [ADDR_WIDTH-1:0]            rom_addr_o,
  input  logic [N_ROWS_ARRAY*F_WIDTH-1:0]  rom_data_i,
  output logic [N_ROWS_ARRAY*F_WIDTH-1:0]  weight_o,
  output logic                             weight_valid_o,
  output logic [COUNTER_ROUND_WIDTH-1:0]   round_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int VEC_W = N_ROWS_ARRAY * F_WIDTH;

  wps_state_t                     state;
  logic [ADDR_WIDTH-1:0]          base;
  logic [COUNTER_ROUND_WIDTH-1:0] n_round;
  logic [COUNTER_ROUND_WIDTH-1:0] issued;
  logic [COUNTER_ROUND_WIDTH-1:0] promoted;
  logic [COUNTER_ROUND_WIDTH-1:0] consumed;
  logic [COUNTER_ROUND_WIDTH-1:0] consumed_next;
  logic [ROM_LATENCY-1:0]         inflight;

  logic issue;
  logic capture;
  logic consume_run;
  logic consume_live;
  logic promote;
  logic shadow_full;

  // Only one read may be outstanding and the shadow must be free to receive it.
  assign issue = (state == RUN) & ~shadow_full & ~(|inflight) & (issued < n_round);
  assign capture = inflight[ROM_LATENCY-1];

  assign consume_run   = consume_i & (state == RUN);
  assign consume_live  = consume_run & weight_valid_o;
  assign consumed_next = consumed + 1'b1;

  assign rom_rd_o   = issue;
  assign rom_addr_o = base + ADDR_WIDTH'(issued);

  weight_prefetch_buffer #(
    .VEC_W (VEC_W)
  ) u_buffer (
    .clk_i         (clk_i),
    .rd_weight_rst (rd_weight_rst),
    .capture       (capture),
    .capture_data  (rom_data_i),
    .consume       (consume_run),
    .promote       (promote),
    .weight        (weight_o),
    .weight_valid  (weight_valid_o),
    .shadow_full   (shadow_full)
  );

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      state    <= IDLE;
      base     <= '0;
      n_round  <= '0;
      issued   <= '0;
      promoted <= '0;
      consumed <= '0;
      inflight <= '0;
      round_o  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      // The in-flight tracker marks the cycle the ROM word becomes valid.
      inflight[0] <= issue;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        inflight[i] <= inflight[i-1];
      end

      done_o <= (state == FINISH);

      if (issue) begin
        issued <= issued + 1'b1;
      end
      if (promote) begin
        round_o  <= promoted;
        promoted <= promoted + 1'b1;
      end
      if (consume_live) begin
        consumed <= consumed_next;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            base     <= base_addr_i;
            n_round  <= n_round_i;
            issued   <= '0;
            promoted <= '0;
            consumed <= '0;
            if (n_round_i != '0) begin
              state  <= RUN;
              busy_o <= 1'b1;
            end else begin
              state  <= FINISH;
            end
          end
        end
        RUN: begin
          if (consume_live && (consumed_next == n_round)) begin
            state  <= FINISH;
            busy_o <= 1'b0;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_prefetch_scheduler.sv
// Bench for weight_prefetch_scheduler: a ROM_LATENCY=1 and a ROM_LATENCY=3
// instance, each fed by a bench ROM and compared every cycle to a round-level model.
module tb_weight_prefetch_scheduler;
  import sparhixcel_pkg::*;

  localparam int AW = 10;
  localparam int CW = 3;
  localparam int VW = 72;
  localparam logic [VW-1:0] JUNK = {9{8'hE7}};
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_FIN  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start   [2];
  logic [AW-1:0] base    [2];
  logic [CW-1:0] nr      [2];
  logic          consume [2];
  logic          rd      [2];
  logic [AW-1:0] addr    [2];
  logic [VW-1:0] rdata   [2];
  logic [VW-1:0] weight  [2];
  logic          wv      [2];
  logic [CW-1:0] round   [2];
  logic          busy    [2];
  logic          done    [2];

  weight_prefetch_scheduler #(.ROM_LATENCY(1)) dut_a (
    .clk_i(clk), .rd_weight_rst(rst), .start_i(start[0]), .base_addr_i(base[0]),
    .n_round_i(nr[0]), .consume_i(consume[0]), .rom_rd_o(rd[0]), .rom_addr_o(addr[0]),
    .rom_data_i(rdata[0]), .weight_o(weight[0]), .weight_valid_o(wv[0]),
    .round_o(round[0]), .busy_o(busy[0]), .done_o(done[0]));

  weight_prefetch_scheduler #(.ROM_LATENCY(3)) dut_b (
    .clk_i(clk), .rd_weight_rst(rst), .start_i(start[1]), .base_addr_i(base[1]),
    .n_round_i(nr[1]), .consume_i(consume[1]), .rom_rd_o(rd[1]), .rom_addr_o(addr[1]),
    .rom_data_i(rdata[1]), .weight_o(weight[1]), .weight_valid_o(wv[1]),
    .round_o(round[1]), .busy_o(busy[1]), .done_o(done[1]));

  function automatic logic [VW-1:0] rom_word(input logic [AW-1:0] a);
    logic [VW-1:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = a[7:0] ^ 8'(i * 37) ^ {6'b0, a[9:8]};
    return w;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Bench ROM: keeps running across DUT resets so late words still appear.
  logic          pv [2][3];
  logic [AW-1:0] pa [2][3];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pv[d][0] <= rd[d];
      pa[d][0] <= addr[d];
      for (int k = 1; k < 3; k++) begin
        pv[d][k] <= pv[d][k-1];
        pa[d][k] <= pa[d][k-1];
      end
    end
  end
  assign rdata[0] = (pv[0][0] === 1'b1) ? rom_word(pa[0][0]) : JUNK;
  assign rdata[1] = (pv[1][2] === 1'b1) ? rom_word(pa[1][2]) : JUNK;

  typedef struct {
    int            phase;
    logic [AW-1:0] base;
    int            n, issued, promoted, consumed;
    bit            pend;
    logic [AW-1:0] pend_addr;
    int            pend_due;
    bit            sh_have;
    logic [VW-1:0] sh_data;
    bit            act_valid;
    logic [VW-1:0] act_data;
    int            round;
    bit            busy, done;
  } mdl_t;

  mdl_t m [2];
  int n_chk, n_fail, cyc;
  int ev_cnt, done_cnt;
  logic          prev_wv    [2];
  logic [CW-1:0] prev_round [2];
  logic [AW-1:0] rdq[$];
  int            rdcyc[$], evcyc[$], evround[$], donecyc[$];
  logic [VW-1:0] evweight[$];
  int sc, lc;

  task automatic chk(input string nm, input int d, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h required %0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no event within budget at cycle %0d, required event", nm, cyc);
  endtask

  task automatic compare_step(input int d);
    bit erd, cap, cons, prom;
    if (rst) begin
      m[d] = '{default: 0};
      chk("rst_rom_rd", d, rd[d], 0);
      chk("rst_weight", d, weight[d], 0);
      chk("rst_valid", d, wv[d], 0);
      chk("rst_round", d, round[d], 0);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_done", d, done[d], 0);
      prev_wv[d] = 1'b0;
      prev_round[d] = '0;
      return;
    end
    erd = (m[d].phase == P_RUN) && !m[d].sh_have && !m[d].pend && (m[d].issued < m[d].n);
    chk("rom_rd", d, rd[d], erd);
    if (erd) chk("rom_addr", d, addr[d], AW'(m[d].base + AW'(m[d].issued)));
    chk("weight", d, weight[d], m[d].act_data);
    chk("weight_valid", d, wv[d], m[d].act_valid);
    chk("round", d, round[d], CW'(m[d].round));
    chk("busy", d, busy[d], m[d].busy);
    chk("done", d, done[d], m[d].done);

    if (rd[d] === 1'b1) begin rdq.push_back(addr[d]); rdcyc.push_back(cyc); end
    if (done[d] === 1'b1) begin done_cnt++; donecyc.push_back(cyc); end
    if (wv[d] === 1'b1 && (prev_wv[d] !== 1'b1 || round[d] !== prev_round[d])) begin
      ev_cnt++;
      evcyc.push_back(cyc);
      evround.push_back(int'(round[d]));
      evweight.push_back(weight[d]);
    end
    prev_wv[d] = wv[d];
    prev_round[d] = round[d];

    // Advance the model across the coming clock edge.
    cap  = m[d].pend && (cyc == m[d].pend_due);
    cons = (m[d].phase == P_RUN) && consume[d] && m[d].act_valid;
    prom = m[d].sh_have && (!m[d].act_valid || cons);
    m[d].done = (m[d].phase == P_FIN);
    if (cons) m[d].consumed++;
    if (prom) begin
      m[d].act_data = m[d].sh_data;
      m[d].act_valid = 1'b1;
      m[d].round = m[d].promoted;
      m[d].promoted++;
      m[d].sh_have = 1'b0;
    end else if (cons) begin
      m[d].act_valid = 1'b0;
    end
    if (cap) begin
      m[d].sh_have = 1'b1;
      m[d].sh_data = rom_word(m[d].pend_addr);
      m[d].pend = 1'b0;
    end
    if (erd) begin
      m[d].pend = 1'b1;
      m[d].pend_addr = AW'(m[d].base + AW'(m[d].issued));
      m[d].pend_due = cyc + lat(d);
      m[d].issued++;
    end
    case (m[d].phase)
      P_IDLE: if (start[d]) begin
        m[d].base = base[d];
        m[d].n = int'(nr[d]);
        m[d].issued = 0;
        m[d].promoted = 0;
        m[d].consumed = 0;
        if (nr[d] != 0) begin m[d].phase = P_RUN; m[d].busy = 1'b1; end
        else m[d].phase = P_FIN;
      end
      P_RUN: if (cons && m[d].consumed == m[d].n) begin m[d].phase = P_FIN; m[d].busy = 1'b0; end
      default: m[d].phase = P_IDLE;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    rdq.delete(); rdcyc.delete(); evcyc.delete(); evround.delete();
    donecyc.delete(); evweight.delete();
  endtask

  task automatic pulse_start(input int d, input logic [AW-1:0] b, input logic [CW-1:0] n);
    start[d] = 1'b1; base[d] = b; nr[d] = n; sc = cyc + 1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic pulse_consume(input int d);
    consume[d] = 1'b1; lc = cyc + 1;
    tick();
    consume[d] = 1'b0;
  endtask

  task automatic wait_ev(input int tgt);
    int g = 0;
    while (ev_cnt < tgt && g < 300) begin tick(); g++; end
    if (ev_cnt < tgt) fail_timeout("wait_round");
  endtask

  task automatic wait_done(input int tgt);
    int g = 0;
    while (done_cnt < tgt && g < 300) begin tick(); g++; end
    if (done_cnt < tgt) fail_timeout("wait_done");
  endtask

  task automatic run_pass(input int d, input logic [AW-1:0] b, input int n, input int gap);
    int ev0 = ev_cnt;
    int dn0 = done_cnt;
    clear_logs();
    pulse_start(d, b, CW'(n));
    for (int r = 0; r < n; r++) begin
      wait_ev(ev0 + r + 1);
      repeat (gap) tick();
      pulse_consume(d);
    end
    wait_done(dn0 + 1);
    repeat (2) tick();
  endtask

  task automatic check_pass(input string nm, input logic [AW-1:0] b, input int n);
    chk({nm, "_reads"}, 0, rdq.size(), n);
    chk({nm, "_rounds"}, 0, evround.size(), n);
    for (int r = 0; r < n && r < rdq.size(); r++)
      chk({nm, "_addr"}, r, rdq[r], AW'(b + AW'(r)));
    for (int r = 0; r < n && r < evround.size(); r++) begin
      chk({nm, "_round_idx"}, r, evround[r], r);
      chk({nm, "_round_word"}, r, evweight[r], rom_word(AW'(b + AW'(r))));
    end
    chk({nm, "_done_pulses"}, 0, donecyc.size(), 1);
  endtask

  initial begin
    int dn0, g, ev0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; base[d] = '0; nr[d] = '0; consume[d] = 1'b0;
    end
    n_chk = 0; n_fail = 0; cyc = 0; ev_cnt = 0; done_cnt = 0;
    fork
      forever begin
        @(negedge clk);
        cyc++;
        compare_step(0);
        compare_step(1);
      end
    join_none

    repeat (3) tick();
    chk("reset_busy", 0, busy[0], 0);
    chk("reset_valid", 1, wv[1], 0);
    rst = 1'b0;
    repeat (2) tick();

    // Base pass, consume ten cycles after each new round.
    run_pass(0, 10'h010, 3, 10);
    check_pass("t1", 10'h010, 3);
    if (rdcyc.size() >= 2 && evcyc.size() >= 1 && donecyc.size() >= 1) begin
      chk("t1_first_read_cycle", 0, rdcyc[0] - sc, 1);
      chk("t1_first_valid_cycle", 0, evcyc[0] - sc, 4);
      chk("t1_second_read_cycle", 0, rdcyc[1] - sc, 4);
      chk("t1_done_after_consume", 0, donecyc[0] - lc, 2);
    end else fail_timeout("t1_event_log");

    // Empty pass.
    clear_logs();
    pulse_start(0, 10'h055, 3'd0);
    repeat (4) tick();
    chk("t2_done_pulses", 0, donecyc.size(), 1);
    if (donecyc.size() >= 1) chk("t2_done_cycle", 0, donecyc[0] - sc, 2);
    chk("t2_reads", 0, rdq.size(), 0);
    chk("t2_busy_after", 0, busy[0], 0);

    // Back-to-back consume in the cycle each round appears.
    clear_logs();
    dn0 = done_cnt;
    pulse_start(0, 10'h040, 3'd4);
    g = 0;
    while (done_cnt == dn0 && g < 200) begin consume[0] = wv[0]; tick(); g++; end
    consume[0] = 1'b0;
    if (done_cnt == dn0) fail_timeout("t3_done");
    repeat (2) tick();
    check_pass("t3", 10'h040, 4);

    // Address wrap.
    run_pass(0, 10'h3FE, 3, 2);
    check_pass("t4", 10'h3FE, 3);
    if (rdq.size() == 3) chk("t4_wrap_addr", 0, rdq[2], 10'h000);

    // Reset while the round-1 read is in flight.
    clear_logs();
    ev0 = ev_cnt;
    pulse_start(0, 10'h080, 3'd4);
    wait_ev(ev0 + 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 0, wv[0], 0);
    chk("t5_rst_busy", 0, busy[0], 0);
    chk("t5_rst_weight", 0, weight[0], 0);
    chk("t5_rst_rd", 0, rd[0], 0);
    #4;
    rst = 1'b0;
    clear_logs();
    repeat (6) tick();
    chk("t5_late_data_dropped", 0, wv[0], 0);
    chk("t5_idle_reads", 0, rdq.size(), 0);
    run_pass(0, 10'h020, 2, 4);
    check_pass("t5", 10'h020, 2);

    // Latency-3 instance with stray start and consume.
    clear_logs();
    ev0 = ev_cnt;
    dn0 = done_cnt;
    pulse_start(1, 10'h100, 3'd3);
    pulse_consume(1);
    wait_ev(ev0 + 1);
    if (rdcyc.size() >= 1 && evcyc.size() >= 1) begin
      chk("t6_first_read_cycle", 1, rdcyc[0] - sc, 1);
      chk("t6_first_valid_cycle", 1, evcyc[0] - rdcyc[0], 5);
    end else fail_timeout("t6_event_log");
    start[1] = 1'b1; base[1] = 10'h200; nr[1] = 3'd1;
    tick();
    start[1] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_ev(ev0 + r + 1);
      repeat (10) tick();
      pulse_consume(1);
    end
    wait_done(dn0 + 1);
    repeat (4) tick();
    check_pass("t6", 10'h100, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_prefetch_scheduler.md
Name: weight_prefetch_scheduler

Overview:
Sequences weight-memory reads for a multi-round convolution pass and feeds the systolic array's weight inputs.
- Fetches one weight vector per round from the weight ROM into a shadow register.
- Promotes the shadow to the active register when the array releases the current round, so the next round's fetch overlaps computation.
- Sits between the weight ROM and the array weight inputs; the SA controller drives it with start/consume.

Parameters:
N_ROWS_ARRAY, 9, weight lanes per vector
F_WIDTH, 8, bits per weight
ADDR_WIDTH, 10, weight ROM address width
COUNTER_ROUND_WIDTH, 3, width of round count/index
ROM_LATENCY, 1, cycles from rom_rd_o to valid rom_data_i (1..3)

Ports:
clk_i  in  1  clock
rd_weight_rst  in  1  reset, asynchronous, active-high
start_i  in  1  pulse: begin pass; ignored while busy_o=1
base_addr_i  in  ADDR_WIDTH  ROM address of round 0; sampled with start_i
n_round_i  in  COUNTER_ROUND_WIDTH  rounds in pass; sampled with start_i
consume_i  in  1  pulse: array finished with active weights
rom_rd_o  out  1  ROM read strobe
rom_addr_o  out  ADDR_WIDTH  ROM address, valid when rom_rd_o=1
rom_data_i  in  N_ROWS_ARRAY*F_WIDTH  ROM data, valid ROM_LATENCY cycles after strobe
weight_o  out  N_ROWS_ARRAY*F_WIDTH  active weight vector, lane i = bits [(i+1)*F_WIDTH-1 : i*F_WIDTH]
weight_valid_o  out  1  weight_o holds a live round
round_o  out  COUNTER_ROUND_WIDTH  index of active round
busy_o  out  1  pass in progress
done_o  out  1  one-cycle pulse at pass end

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; active and shadow registers 0.
  - All counters 0; FSM in IDLE; shadow_full=0; no read in flight.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: start_i & n_round_i≠0 → RUN. Latch base/n_round; issued=0, promoted=0, consumed=0; busy_o=1 from next cycle.
  - IDLE: start_i & n_round_i=0 → FINISH. No ROM read.
  - RUN: consumed reaches n_round → FINISH.
  - FINISH: done_o=1 for exactly one cycle, busy_o=0, weight_valid_o=0 → IDLE.
- Fetch engine (RUN only):
  - Issue when shadow_full=0, no read in flight, and issued<n_round.
  - On issue: rom_rd_o=1 for one cycle, rom_addr_o=base+issued (modulo 2^ADDR_WIDTH wrap), issued++.
  - rom_data_i is captured into the shadow at the end of cycle issue+ROM_LATENCY; shadow_full=1 next cycle.
  - At most one read outstanding.
- Promote: at a clock edge where shadow_full=1 and (weight_valid_o=0 or consume_i=1):
  - active←shadow, shadow_full←0, weight_valid_o←1.
  - round_o←promoted, then promoted++.
- consume_i:
  - With weight_valid_o=0: ignored, no count.
  - Otherwise: consumed++.
  - If no promote occurs in that same cycle, weight_valid_o←0. weight_o holds its value; it is not cleared.
- Simultaneous events:
  - consume_i with shadow capture in the same cycle: capture wins the shadow, promote happens next cycle.
  - consume_i with shadow_full in the same cycle: promote in that cycle.
- Latency with ROM_LATENCY=1 and start_i in cycle 0:
  - rom_rd_o=1 in cycle 1; data captured end of cycle 2.
  - weight_valid_o=1 from cycle 4.
  - Second read issued cycle 4.
- Reset mid-pass:
  - Immediate abort to reset state; no done_o.
  - Any ROM data returning after reset is discarded (in-flight tracker cleared).
- start_i during RUN/FINISH ignored; consume_i in IDLE/FINISH ignored.

Decomposition:
- Shared package sparhixcel_pkg holds:
  - The array constants N_ROWS_ARRAY, F_WIDTH, COUNTER_ROUND_WIDTH and the weight ROM address width.
  - typedef weight_vec_t (logic [N_ROWS_ARRAY*F_WIDTH-1:0]).
  - enum wps_state_t {IDLE, RUN, FINISH}.
- One sub-module, weight_prefetch_buffer:
  - Contains the shadow+active register pair with shadow_full/valid flags.
  - Handles capture/promote/consume logic.
- The top level holds the FSM, the issue counter and the ROM_LATENCY in-flight shift register.

Test Plan:
1. Reset, then start_i, base=0x010, n_round=3, ROM_LATENCY=1; consume_i 10 cycles after each weight_valid_o rise.
   - Reads at 0x010, 0x011, 0x012.
   - round_o 0,1,2; weight_o matches ROM words.
   - done_o single pulse after the third consume; exactly 3 rom_rd_o pulses.
2. n_round=0 start → done_o pulse two cycles after start; rom_rd_o never asserted; busy_o=0 after.
3. consume_i asserted in the cycle weight_valid_o first rises, every round (back-to-back), n_round=4:
   - Promotion waits for the prefetch; no round skipped or duplicated.
   - Rounds 0..3 in order; 4 reads total.
4. base=0x3FE, n_round=3 → addresses 0x3FE, 0x3FF, 0x000.
5. rd_weight_rst pulsed while a read is in flight during round 1 of 4:
   - All outputs 0 immediately.
   - Late rom_data_i not captured.
   - A new start_i with base=0x020 runs cleanly from 0x020.
6. ROM_LATENCY=3; start_i pulsed again mid-pass; consume_i with weight_valid_o=0:
   - Data captured 3 cycles after the strobe.
   - The extra start and the stray consume have no effect; the round count is unchanged.
